spi_master_ctrl: RTL and testbench

Host-side SPI transaction sequencer that drives the Lab2 SPI memory slave (the `fsm`-controlled shift-register/data-memory block). Accepts single-byte read/write requests on a valid/ready handshake, generates `cs_pin`/`sclk_pin`/`mosi_pin` framing that walks the slave through GET→GOT→READ*/WRITE*→DONE, samples `miso_pin`, and returns read data on a one-cycle response strobe.

---
 rtl/spi_master_ctrl_if.sv | 29 ++
 rtl/spi_master_ctrl.sv | 174 +++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_ctrl_if.sv
// spi_master_ctrl_if: request/response handshake and SPI pins of the
// host-side SPI sequencer.
interface spi_master_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_rw;
    logic [6:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       cs_pin;
    logic       sclk_pin;
    logic       mosi_pin;
    logic       miso_pin;

    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, miso_pin,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        output cs_pin, sclk_pin, mosi_pin
    );

    modport master (
        output req_valid, req_rw, req_addr, req_wdata, miso_pin,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
        input  cs_pin, sclk_pin, mosi_pin
    );
endinterface

// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: host-side SPI mode-0 sequencer for the Lab2 SPI memory slave.
// Define SPI_CTRL_READBACK_EN to auto-read back every write and flag mismatches.
module spi_master_ctrl #(
    parameter int CLKDIV  = 5,
    parameter int CS_IDLE = 2
) (
    input logic              clk,
    input logic              reset_n,
    spi_master_ctrl_if.slave bus
);

`ifdef SPI_CTRL_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int GW = $clog2(CS_IDLE + 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLKDIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_IDLE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

    state_e        state_q;
    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic          tick;
    logic [GW-1:0] gap_q;
    logic [3:0]    bit_q;
    logic [15:0]   tx_q;
    logic [7:0]    rx_q;
    logic          rw_q;
    logic [6:0]    addr_q;
    logic [7:0]    wdata_q;
    logic          rb_q;
    logic          chk_q;
    logic          cs_q;
    logic          sclk_q;
    logic          mosi_q;
    logic          ready_q;
    logic          busy_q;
    logic          rsp_valid_q;
    logic [7:0]    rdata_q;
    logic          err_q;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            div_q       <= '0;
            gap_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rb_q        <= 1'b0;
            chk_q       <= 1'b0;
            cs_q        <= 1'b1;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            div_q       <= div_d;
            unique case (state_q)
                S_IDLE: begin
                    div_q <= '0;
                    // A pending readback reuses the write's address as a read frame
                    if (rb_q) begin
                        state_q <= S_SETUP;
                        cs_q    <= 1'b0;
                        bit_q   <= '0;
                        rw_q    <= 1'b1;
                        tx_q    <= {addr_q, 1'b1, 8'h00};
                        mosi_q  <= addr_q[6];
                        rb_q    <= 1'b0;
                        chk_q   <= 1'b1;
                    end else if (bus.req_valid && ready_q) begin
                        state_q <= S_SETUP;
                        cs_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        bit_q   <= '0;
                        rw_q    <= bus.req_rw;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        tx_q    <= {bus.req_addr, bus.req_rw,
                                    bus.req_rw ? 8'h00 : bus.req_wdata};
                        mosi_q  <= bus.req_addr[6];
                        chk_q   <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (tick) begin
                        state_q <= S_SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (tick) begin
                        if (sclk_q) begin
                            sclk_q <= 1'b0;
                            if (bit_q == 4'd15) begin
                                state_q <= S_HOLD;
                                mosi_q  <= 1'b0;
                            end else begin
                                bit_q  <= bit_q + 4'd1;
                                tx_q   <= {tx_q[14:0], 1'b0};
                                mosi_q <= tx_q[14];
                            end
                        end else begin
                            sclk_q <= 1'b1;
                            if (rw_q && bit_q[3])
                                rx_q <= {rx_q[6:0], bus.miso_pin};
                        end
                    end
                end
                S_HOLD: begin
                    if (tick) begin
                        state_q <= S_GAP;
                        cs_q    <= 1'b1;
                        gap_q   <= '0;
                        if (rw_q) begin
                            rsp_valid_q <= 1'b1;
                            rdata_q     <= rx_q;
                            err_q       <= RB_EN && chk_q && (rx_q != wdata_q);
                        end else if (RB_EN) begin
                            rb_q <= 1'b1;
                        end
                    end
                end
                S_GAP: begin
                    div_q <= '0;
                    gap_q <= gap_q + 1'b1;
                    if (gap_q == GAP_LAST) begin
                        state_q <= S_IDLE;
                        if (!rb_q) begin
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign bus.cs_pin    = cs_q;
    assign bus.sclk_pin  = sclk_q;
    assign bus.mosi_pin  = mosi_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb_spi_master_ctrl: table vectors, corner sequences and random requests
// against a frame-level reference model and a behavioural SPI memory slave.
module tb_spi_master_ctrl;
    localparam int C   = 5;
    localparam int CSI = 2;
    localparam int P   = 1 + 33 * C + CSI;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    spi_master_ctrl_if bus ();

    spi_master_ctrl #(.CLKDIV(C), .CS_IDLE(CSI)) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int nvec = 0;
    int nerr = 0;
    bit stuck = 1'b0;
    bit prev_chain = 1'b0;
    logic [7:0] rmem [128];
    logic [7:0] smem [128];

    function automatic logic [7:0] pat(input int i);
        return (i == 17) ? 8'h9E : 8'(i * 37 + 11);
    endfunction

    // Behavioural SPI memory slave: 7-bit addr, rw, 8 data bits, mode 0
    always begin : slave
        int s_cnt;
        logic [15:0] s_sh;
        logic [7:0] s_out;
        logic ps, pc;
        s_cnt = 0;
        s_sh = '0;
        s_out = '0;
        ps = 1'b0;
        pc = 1'b1;
        bus.miso_pin = 1'b0;
        for (int i = 0; i < 128; i++) smem[i] = pat(i);
        forever begin
            @(bus.sclk_pin or bus.cs_pin);
            if (bus.cs_pin === 1'b1 && pc !== 1'b1) begin
                if (s_cnt == 16 && !s_sh[8])
                    smem[s_sh[15:9]] = stuck ? (s_sh[7:0] & 8'hFE) : s_sh[7:0];
                s_cnt = 0;
            end else if (bus.cs_pin === 1'b0) begin
                if (bus.sclk_pin === 1'b1 && ps !== 1'b1) begin
                    s_sh = {s_sh[14:0], bus.mosi_pin};
                    s_cnt++;
                    if (s_cnt == 8 && s_sh[0]) s_out = smem[s_sh[7:1]];
                end else if (bus.sclk_pin === 1'b0 && ps === 1'b1) begin
                    if (s_cnt >= 8 && s_cnt < 16) bus.miso_pin = s_out[15 - s_cnt];
                end
            end
            ps = bus.sclk_pin;
            pc = bus.cs_pin;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run(input logic rw, input logic [6:0] a, input logic [7:0] d,
                       input bit chain, input logic [15:0] exp_mosi,
                       input logic [7:0] exp_rd, input string tag);
        int w, nrise, nrsp, rsp_cyc, rdy_cyc, cs_hi, exp_len, exp_edges;
        int exp_rsp_n, exp_rsp_cyc, ec;
        logic [31:0] cap;
        logic [7:0] rsp_d, exp_d;
        logic rsp_e, exp_e, prev_sclk;
        bit edges_ok;
        bus.req_valid = 1'b1;
        bus.req_rw    = rw;
        bus.req_addr  = a;
        bus.req_wdata = d;
        w = 0;
        while (bus.req_ready !== 1'b1 && w < 700) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_acc_timeout"}, 32'(w >= 700), 0);
        if (prev_chain) chk({tag, "_b2b_wait"}, w, 0);
        if (!rw) rmem[a] = stuck ? (d & 8'hFE) : d;
        exp_d = 8'h00;
        exp_e = 1'b0;
        exp_len = P;
        exp_edges = 16;
        exp_rsp_n = 0;
        exp_rsp_cyc = 1 + 33 * C;
        if (rw) begin
            exp_rsp_n = 1;
            exp_d = exp_rd;
        end
`ifdef SPI_CTRL_READBACK_EN
        else begin
            exp_len = 2 * P;
            exp_edges = 32;
            exp_rsp_n = 1;
            exp_rsp_cyc = P + 1 + 33 * C;
            exp_d = rmem[a];
            exp_e = (rmem[a] != d);
        end
`endif
        nrise = 0; nrsp = 0; rsp_cyc = -1; rdy_cyc = -1; cs_hi = 0;
        cap = '0; rsp_d = '0; rsp_e = 1'b0; prev_sclk = 1'b0; edges_ok = 1'b1;
        for (int k = 1; k <= 800; k++) begin
            @(negedge clk);
            if (k == 1) begin
                chk({tag, "_cyc1_cs_rdy_busy"},
                    {bus.cs_pin, bus.req_ready, bus.busy}, 3'b001);
                if (!chain) bus.req_valid = 1'b0;
            end
            if (bus.sclk_pin && !prev_sclk) begin
                ec = (nrise / 16) * P + 1 + C + 2 * (nrise % 16) * C;
                if (k != ec || bus.cs_pin !== 1'b0) edges_ok = 1'b0;
                if (nrise < 32) cap = {cap[30:0], bus.mosi_pin};
                nrise++;
            end
            prev_sclk = bus.sclk_pin;
            if (bus.rsp_valid) begin
                nrsp++;
                rsp_cyc = k;
                rsp_d = bus.rsp_rdata;
                rsp_e = bus.rsp_err;
            end
            if (bus.cs_pin) cs_hi++;
            else cs_hi = 0;
            if (bus.req_ready) begin
                rdy_cyc = k;
                break;
            end
        end
        chk({tag, "_ready_cycle"}, rdy_cyc, exp_len);
        chk({tag, "_rise_count"}, nrise, exp_edges);
        chk({tag, "_edge_timing"}, 32'(edges_ok), 1);
        chk({tag, "_mosi"}, (exp_edges == 32) ? cap[31:16] : cap[15:0], exp_mosi);
        if (exp_edges == 32) chk({tag, "_rb_mosi"}, cap[15:0], {a, 1'b1, 8'h00});
        chk({tag, "_rsp_count"}, nrsp, exp_rsp_n);
        if (exp_rsp_n == 1) begin
            chk({tag, "_rsp_cycle"}, rsp_cyc, exp_rsp_cyc);
            chk({tag, "_rsp_rdata"}, rsp_d, exp_d);
            chk({tag, "_rsp_err"}, rsp_e, exp_e);
        end
        chk({tag, "_cs_gap_ok"}, 32'(cs_hi >= CSI), 1);
        prev_chain = chain;
    endtask

    typedef struct {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
        bit         chain;
        logic [15:0] mosi;
        logic [7:0] rdata;
    } vec_t;

    initial begin : wdog
        #5ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t tbl [5];
        int cnt, n;
        logic rw;
        logic [6:0] a;
        logic [7:0] d;
        bit ch;
        tbl[0] = '{1'b0, 7'h2A, 8'hC3, 1'b0, 16'h54C3, 8'h00};
        tbl[1] = '{1'b1, 7'h11, 8'h00, 1'b0, 16'h2300, 8'h9E};
        tbl[2] = '{1'b0, 7'h05, 8'h7E, 1'b1, 16'h0A7E, 8'h00};
        tbl[3] = '{1'b1, 7'h05, 8'h00, 1'b0, 16'h0B00, 8'h7E};
        tbl[4] = '{1'b1, 7'h2A, 8'h00, 1'b0, 16'h5500, 8'hC3};
        for (int i = 0; i < 128; i++) rmem[i] = pat(i);
        bus.req_valid = 1'b0;
        bus.req_rw    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;

        repeat (3) @(negedge clk);
        chk("rst_pins_cs_sclk_mosi", {bus.cs_pin, bus.sclk_pin, bus.mosi_pin}, 3'b100);
        chk("rst_rdy_busy_rsp", {bus.req_ready, bus.busy, bus.rsp_valid}, 3'b100);
        chk("rst_rdata_err", {bus.rsp_rdata, bus.rsp_err}, 9'h000);
        reset_n = 1'b1;
        cnt = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus.sclk_pin || !bus.cs_pin || bus.rsp_valid) cnt++;
        end
        chk("idle_activity", cnt, 0);

        for (int i = 0; i < 5; i++)
            run(tbl[i].rw, tbl[i].addr, tbl[i].wdata, tbl[i].chain,
                tbl[i].mosi, tbl[i].rdata, $sformatf("tbl%0d", i));

        // Reset in the middle of a read frame
        bus.req_valid = 1'b1;
        bus.req_rw    = 1'b1;
        bus.req_addr  = 7'h11;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 700) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        repeat (80) @(negedge clk);
        chk("arst_pre_cs", bus.cs_pin, 0);
        reset_n = 1'b0;
        #1;
        chk("arst_async_outs", {bus.cs_pin, bus.sclk_pin, bus.req_ready, bus.busy},
            4'b1010);
        bus.req_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (bus.rsp_valid || !bus.cs_pin) cnt++;
        end
        chk("arst_no_rsp_cs_high", cnt, 0);
        prev_chain = 1'b0;
        run(1'b1, 7'h2A, 8'h00, 1'b0, 16'h5500, rmem[7'h2A], "post_arst");

        // Slave with data bit 0 stuck low
        stuck = 1'b1;
        run(1'b0, 7'h33, 8'hA5, 1'b0, 16'h66A5, 8'h00, "stuck_wr");
        run(1'b1, 7'h33, 8'h00, 1'b0, 16'h6700, 8'hA4, "stuck_rd");
        stuck = 1'b0;

        for (int i = 0; i < 16; i++) begin
            rw = 1'($urandom_range(0, 1));
            a  = 7'($urandom_range(0, 127));
            d  = 8'($urandom);
            ch = (i != 15) && ($urandom_range(0, 1) == 1);
            run(rw, a, d, ch, {a, rw, rw ? 8'h00 : d}, rmem[a],
                $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
